// File: rtl/decoder_4to16.sv
// 4-to-16 one-hot decoder with enable, selectable output polarity and an
// optional output register stage (1-cycle latency, synchronous reset).
module decoder_4to16 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit REGISTERED     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  data_in,
    output logic [15:0] data_out,
    output logic        valid
);

    // Pattern driven when no output is selected; XOR with it applies polarity.
    localparam logic [15:0] INACTIVE = OUT_ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic [15:0] onehot;
    logic [15:0] data_out_d;
    logic        valid_d;

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[data_in] = 1'b1;
        end
        data_out_d = onehot ^ INACTIVE;
        valid_d    = en;
    end

    if (REGISTERED) begin : g_reg
        logic [15:0] data_out_q;
        logic        valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_out_q <= INACTIVE;
                valid_q    <= 1'b0;
            end else begin
                data_out_q <= data_out_d;
                valid_q    <= valid_d;
            end
        end

        assign data_out = data_out_q;
        assign valid    = valid_q;
    end else begin : g_comb
        // Clock and reset have no role in the purely combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign data_out = data_out_d;
        assign valid    = valid_d;
    end

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed bench for decoder_4to16: default registered build, active-low
// build and combinational build driven from the same stimulus.
module tb_decoder_4to16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  data_in;
    logic [15:0] dout_hi, dout_lo, dout_cb;
    logic        vld_hi, vld_lo, vld_cb;

    int tests_run = 0;
    int tests_failed = 0;

    decoder_4to16 u_dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in),
        .data_out(dout_hi), .valid(vld_hi)
    );

    decoder_4to16 #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) u_al (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in),
        .data_out(dout_lo), .valid(vld_lo)
    );

    decoder_4to16 #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) u_comb (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in),
        .data_out(dout_cb), .valid(vld_cb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_w;

        rst = 1'b1; en = 1'b1; data_in = 4'h5;
        tick();
        chk("rst1_dout", dout_hi, 16'h0000);
        chk("rst1_valid", {15'd0, vld_hi}, 16'h0000);
        chk("rst1_al_dout", dout_lo, 16'hFFFF);
        tick();
        chk("rst2_dout", dout_hi, 16'h0000);
        chk("rst2_valid", {15'd0, vld_hi}, 16'h0000);

        // Downward sweep, one code per cycle; first code sampled on release edge.
        rst = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            data_in = 4'(i);
            #1;
            exp_w = 16'h0001 << i;
            chk("sweep_comb", dout_cb, exp_w);
            tick();
            chk("sweep_dout", dout_hi, exp_w);
            chk("sweep_valid", {15'd0, vld_hi}, 16'h0001);
            chk("sweep_onehot", 16'($countones(dout_hi)), 16'd1);
            chk("sweep_al", dout_lo, ~exp_w);
        end

        // Upward sweep exercising the opposite direction.
        for (int i = 0; i < 16; i++) begin
            data_in = 4'(i);
            tick();
            chk("up_dout", dout_hi, 16'h0001 << i);
        end

        // Jumps between extremes.
        data_in = 4'h0; tick(); chk("jump0", dout_hi, 16'h0001);
        data_in = 4'hF; tick(); chk("jumpF", dout_hi, 16'h8000);
        data_in = 4'h6; tick(); chk("jump6", dout_hi, 16'h0040);

        // Enable gating.
        en = 1'b0; data_in = 4'h3;
        #1;
        chk("en0_comb", dout_cb, 16'h0000);
        chk("en0_comb_valid", {15'd0, vld_cb}, 16'h0000);
        tick();
        chk("en0_dout", dout_hi, 16'h0000);
        chk("en0_valid", {15'd0, vld_hi}, 16'h0000);
        chk("en0_al", dout_lo, 16'hFFFF);
        en = 1'b1;
        tick();
        chk("en1_dout", dout_hi, 16'h0008);
        chk("en1_valid", {15'd0, vld_hi}, 16'h0001);

        // Active-low build, then reset forces the inactive pattern.
        data_in = 4'h2;
        tick();
        chk("al_dout", dout_lo, 16'hFFFB);
        chk("al_valid", {15'd0, vld_lo}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("comb_ignores_rst", dout_cb, 16'h0004);
        chk("comb_valid_rst", {15'd0, vld_cb}, 16'h0001);
        tick();
        chk("al_rst_dout", dout_lo, 16'hFFFF);
        chk("al_rst_valid", {15'd0, vld_lo}, 16'h0000);
        chk("hi_rst_prio", dout_hi, 16'h0000);

        // Reset in the middle of a sequence.
        rst = 1'b0; data_in = 4'hB;
        tick();
        chk("mid_pre", dout_hi, 16'h0800);
        rst = 1'b1; data_in = 4'hA;
        tick();
        chk("mid_rst_dout", dout_hi, 16'h0000);
        chk("mid_rst_valid", {15'd0, vld_hi}, 16'h0000);
        rst = 1'b0; data_in = 4'h9;
        tick();
        chk("mid_post_dout", dout_hi, 16'h0200);
        chk("mid_post_valid", {15'd0, vld_hi}, 16'h0001);

        // Combinational build: same-cycle decode.
        data_in = 4'h7;
        #1;
        chk("comb7", dout_cb, 16'h0080);
        chk("comb7_valid", {15'd0, vld_cb}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decoder_4to16.md
DECODER_4TO16 -- requirements
Module: decoder_4to16

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 0: when 0 the selected output bit is 1 and all others are 0; when 1 the selected bit is 0 and all others are 1.
REQ-002 Parameter REGISTERED, default 1: when 1 the outputs are registered with 1-cycle latency; when 0 the outputs are combinational from the inputs.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port en, input, 1 bit: decode enable.
REQ-006 Port data_in, input, 4 bits: binary select code, 0..15.
REQ-007 Port data_out, output, 16 bits: one-hot decoded word (polarity per OUT_ACTIVE_LOW).
REQ-008 Port valid, output, 1 bit: high when data_out carries a decode of an enabled input.

Function
REQ-009 With en=1, the logical (active-high) one-hot word SHALL have exactly bit data_in set; e.g. data_in=4'hF gives bit 15, data_in=4'h0 gives bit 0.
REQ-010 With en=0, the logical word SHALL have no bit set, and valid SHALL be 0.
REQ-011 data_out SHALL equal the logical word when OUT_ACTIVE_LOW=0, and its bitwise inverse when OUT_ACTIVE_LOW=1.
REQ-012 REGISTERED=1: data_out and valid SHALL reflect the en and data_in values sampled at the previous rising clk edge (latency exactly 1 cycle).
REQ-013 REGISTERED=1: a new data_in value SHALL be accepted every cycle, with no stall and no dead cycles.
REQ-014 REGISTERED=0: data_out and valid SHALL follow en and data_in combinationally; rst has no effect on outputs in this mode.
REQ-015 When en=1, valid SHALL equal 1, with the same latency as data_out.
REQ-016 At most one data_out bit SHALL be in the active state in any cycle.
REQ-017 Consecutive codes (15 down to 0, 0 up to 15, or any jump) SHALL each produce the correct one-hot word with no glitch cycle between them at the registered output.
REQ-018 No X or Z SHALL appear on the outputs after the first reset.

Reset
REQ-019 REGISTERED=1: while rst=1 at a rising clk edge, data_out SHALL load the inactive pattern (16'h0000 when OUT_ACTIVE_LOW=0, 16'hFFFF when OUT_ACTIVE_LOW=1), and valid SHALL load 0.
REQ-020 rst SHALL take priority over en and data_in when both are asserted in the same cycle.
REQ-021 The first cycle after rst deasserts SHALL decode the inputs sampled at that edge normally.
REQ-022 Asserting rst mid-sequence SHALL clear the outputs at the next edge, with no residual state carried over.

Verification
REQ-023 Reset: rst=1 for 2 cycles with en=1 and data_in=4'h5 -> data_out=16'h0000 and valid=0 throughout the reset.
REQ-024 Downward sweep: en=1, data_in driven 4'hF down to 4'h0, one per cycle -> data_out sequence 16'h8000, 16'h4000, ... 16'h0001, each one cycle late, with valid=1.
REQ-025 Enable: en=0 with data_in=4'h3 -> data_out=16'h0000 and valid=0; then en=1 -> data_out=16'h0008 on the next cycle.
REQ-026 Active-low build: OUT_ACTIVE_LOW=1, data_in=4'h2, en=1 -> data_out=16'hFFFB; reset -> data_out=16'hFFFF.
REQ-027 Reset mid-sweep: rst=1 while data_in=4'hA -> next cycle data_out=16'h0000; after release with data_in=4'h9 -> data_out=16'h0200.
REQ-028 Combinational build: REGISTERED=0, data_in=4'h7, en=1 -> data_out=16'h0080 in the same cycle.
